unpacker: RTL and testbench

//  Decompression-side inverse of the packer. Accepts the compressed byte stream
//  (MSB-first bit order, final byte partially filled) and serves variable-length
//  bit fields of 1..64 bits on request, right-aligned, to the downstream code decoder.

---
 rtl/unpacker.sv | 79 +++++++
 tb/tb_unpacker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/unpacker.sv
// Bit-stream unpacker: buffers an MSB-first byte stream and serves right-aligned
// fields of 1..64 bits on request, flagging illegal lengths and reads past end.
module unpacker #(
    parameter int BUF_W = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        last_byte,
    input  logic [3:0]  valid_bits,
    output logic        byte_ready,
    input  logic        req,
    input  logic [6:0]  bits_req,
    output logic [63:0] code_out,
    output logic        code_valid,
    output logic        stream_done,
    output logic        err
);
    localparam logic [7:0] FILL_MAX = 8'(BUF_W - 8);

    logic [BUF_W-1:0] bit_buf, buf_shift, buf_next, byte_wide;
    logic [7:0]       count, count_shift, count_next, req_len, byte_masked;
    logic [3:0]       n_bits;
    logic [63:0]      field;
    logic             eos, eos_next, err_next;
    logic             evaluate, len_bad, take, ext_err, accept, bad_last;

    assign byte_ready = !rst && !eos && !err && (count <= FILL_MAX);

    always_comb begin
        req_len   = {1'b0, bits_req};
        len_bad   = (bits_req == 7'd0) || (bits_req > 7'd64);
        // A field is only looked at between pulses, which caps the rate at one per 2 cycles.
        evaluate  = req && !code_valid && !err;
        take      = evaluate && !len_bad && (count >= req_len);
        ext_err   = evaluate && (len_bad || (eos && (count < req_len)));
        accept    = data_valid && byte_ready;
        bad_last  = accept && last_byte && ((valid_bits == 4'd0) || (valid_bits > 4'd8));
        n_bits    = last_byte ? valid_bits : 4'd8;
        byte_masked = data_in & (8'hFF << (4'd8 - n_bits));
        field     = bit_buf[BUF_W-1 -: 64] >> (7'd64 - bits_req);

        // Extraction happens first so an incoming byte lands right after the surviving bits.
        buf_shift   = take ? (bit_buf << bits_req) : bit_buf;
        count_shift = take ? (count - req_len) : count;
        byte_wide   = {byte_masked, {(BUF_W-8){1'b0}}} >> count_shift;

        buf_next   = buf_shift;
        count_next = count_shift;
        if (accept && !bad_last) begin
            buf_next   = buf_shift | byte_wide;
            count_next = count_shift + {4'b0, n_bits};
        end
        eos_next = eos || (accept && last_byte && !bad_last);
        err_next = err || ext_err || bad_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_buf     <= '0;
            count       <= '0;
            eos         <= 1'b0;
            err         <= 1'b0;
            code_out    <= '0;
            code_valid  <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            bit_buf     <= buf_next;
            count       <= count_next;
            eos         <= eos_next;
            err         <= err_next;
            code_valid  <= take;
            if (take)
                code_out <= field;
            stream_done <= eos_next && (count_next == 8'd0) && !err_next;
        end
    end
endmodule

// File: tb/tb_unpacker.sv
// Directed bench for unpacker: round-trip decode, starvation, full buffer,
// same-cycle append/extract, end-of-stream errors and mid-stream reset.
module tb_unpacker;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        last_byte;
    logic [3:0]  valid_bits;
    logic        byte_ready;
    logic        req;
    logic [6:0]  bits_req;
    logic [63:0] code_out;
    logic        code_valid;
    logic        stream_done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    unpacker #(.BUF_W(128)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .last_byte(last_byte), .valid_bits(valid_bits), .byte_ready(byte_ready),
        .req(req), .bits_req(bits_req), .code_out(code_out), .code_valid(code_valid),
        .stream_done(stream_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; data_valid = 1'b0; last_byte = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic [3:0] vb);
        chk("byte_ready_before_send", {63'b0, byte_ready}, 64'd1);
        data_in = b; data_valid = 1'b1; last_byte = last; valid_bits = vb;
        tick();
        data_valid = 1'b0; last_byte = 1'b0;
    endtask

    task automatic get_field(input logic [6:0] n, output logic [63:0] v);
        req = 1'b1; bits_req = n; v = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (code_valid) begin
                v = code_out;
                break;
            end
        end
        req = 1'b0;
        chk("field_code_valid", {63'b0, code_valid}, 64'd1);
    endtask

    logic [63:0]  v;
    logic [127:0] pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        data_in = '0; valid_bits = 4'd8; bits_req = 7'd1;
        rst = 1'b1; req = 1'b0; data_valid = 1'b0; last_byte = 1'b0;
        tick();
        tick();
        chk("rst_byte_ready", {63'b0, byte_ready}, 64'd0);
        chk("rst_code_out", code_out, 64'd0);
        chk("rst_code_valid", {63'b0, code_valid}, 64'd0);
        chk("rst_stream_done", {63'b0, stream_done}, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_byte_ready", {63'b0, byte_ready}, 64'd1);

        // 1: round trip
        send_byte(8'h8C, 1'b0, 4'd8);
        send_byte(8'hAB, 1'b0, 4'd8);
        send_byte(8'hED, 1'b0, 4'd8);
        send_byte(8'hB5, 1'b0, 4'd8);
        send_byte(8'hE7, 1'b0, 4'd8);
        send_byte(8'h80, 1'b1, 4'd1);
        chk("t1_eos_byte_ready", {63'b0, byte_ready}, 64'd0);
        get_field(7'd5, v);
        chk("t1_f5", v, 64'd17);
        chk("t1_done_early", {63'b0, stream_done}, 64'd0);
        tick();
        chk("t1_pulse_width", {63'b0, code_valid}, 64'd0);
        get_field(7'd16, v);
        chk("t1_f16", v, 64'd38269);
        get_field(7'd11, v);
        chk("t1_f11", v, 64'd1461);
        get_field(7'd9, v);
        chk("t1_f9", v, 64'd463);
        chk("t1_stream_done", {63'b0, stream_done}, 64'd1);
        chk("t1_err", {63'b0, err}, 64'd0);
        tick();
        chk("t1_code_out_hold", code_out, 64'd463);

        // 2: starvation
        do_reset();
        send_byte(8'hA5, 1'b0, 4'd8);
        req = 1'b1; bits_req = 7'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_starved", {63'b0, code_valid}, 64'd0);
        end
        data_in = 8'h3C; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("t2_accept_edge", {63'b0, code_valid}, 64'd0);
        tick();
        chk("t2_code_valid", {63'b0, code_valid}, 64'd1);
        chk("t2_code", code_out, 64'hA53);
        req = 1'b0;

        // 3: full buffer
        do_reset();
        pat = 128'h0123456789ABCDEFFEDCBA9876543210;
        for (int i = 0; i < 16; i++)
            send_byte(pat[127-8*i -: 8], 1'b0, 4'd8);
        chk("t3_full_not_ready", {63'b0, byte_ready}, 64'd0);
        get_field(7'd64, v);
        chk("t3_word0", v, 64'h0123456789ABCDEF);
        chk("t3_ready_again", {63'b0, byte_ready}, 64'd1);
        get_field(7'd64, v);
        chk("t3_word1", v, 64'hFEDCBA9876543210);

        // 4: same-cycle append and extract
        do_reset();
        send_byte(8'h5A, 1'b0, 4'd8);
        req = 1'b1; bits_req = 7'd8;
        data_in = 8'hC3; data_valid = 1'b1;
        tick();
        req = 1'b0; data_valid = 1'b0;
        chk("t4_code_valid", {63'b0, code_valid}, 64'd1);
        chk("t4_old_byte", code_out, 64'h5A);
        tick();
        get_field(7'd8, v);
        chk("t4_new_byte", v, 64'hC3);

        // 5: past end of stream and illegal lengths
        do_reset();
        send_byte(8'hE0, 1'b1, 4'd3);
        req = 1'b1; bits_req = 7'd4;
        tick();
        chk("t5_err", {63'b0, err}, 64'd1);
        chk("t5_no_code", {63'b0, code_valid}, 64'd0);
        bits_req = 7'd3;
        tick();
        tick();
        req = 1'b0;
        chk("t5_req_ignored", {63'b0, code_valid}, 64'd0);
        chk("t5_not_ready", {63'b0, byte_ready}, 64'd0);
        chk("t5_not_done", {63'b0, stream_done}, 64'd0);
        do_reset();
        send_byte(8'hFF, 1'b0, 4'd8);
        req = 1'b1; bits_req = 7'd0;
        tick();
        req = 1'b0;
        chk("t5_len0_err", {63'b0, err}, 64'd1);
        chk("t5_len0_no_code", {63'b0, code_valid}, 64'd0);
        do_reset();
        req = 1'b1; bits_req = 7'd65;
        tick();
        req = 1'b0;
        chk("t5_len65_err", {63'b0, err}, 64'd1);

        // 6: reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++)
            send_byte(8'h11 * (i + 1), 1'b0, 4'd8);
        req = 1'b1; bits_req = 7'd50; rst = 1'b1;
        tick();
        rst = 1'b0; req = 1'b0;
        #1;
        chk("t6_code_valid", {63'b0, code_valid}, 64'd0);
        chk("t6_err", {63'b0, err}, 64'd0);
        chk("t6_done", {63'b0, stream_done}, 64'd0);
        chk("t6_byte_ready", {63'b0, byte_ready}, 64'd1);
        send_byte(8'hF0, 1'b0, 4'd8);
        send_byte(8'h0F, 1'b1, 4'd8);
        get_field(7'd16, v);
        chk("t6_fresh", v, 64'hF00F);
        chk("t6_fresh_done", {63'b0, stream_done}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
